// File: rtl/pipe_adder_sub.sv
// Carry-chained pipelined WIDTH-bit add/subtract with valid/ready handshake.
// Each rank resolves one CW-bit chunk, so the carry chain is cut once per clock.
module pipe_adder_sub #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Operands are only needed up to the last rank that consumes a chunk.
  logic [WIDTH-1:0] a_q   [0:STAGES-1];
  logic [WIDTH-1:0] b_q   [0:STAGES-1];
  logic [WIDTH-1:0] sum_q [0:STAGES];
  logic             c_q   [0:STAGES];
  logic             v_q   [0:STAGES];
  logic             ovf_q;

  logic [CW-1:0]    ns     [1:STAGES];
  logic             nc     [1:STAGES];
  logic [WIDTH-1:0] sum_nx [1:STAGES];
  logic             stall;

  assign stall    = v_q[STAGES] && !out_ready;
  assign in_ready = !stall;

  // Per-rank chunk add, merged into the partially built sum.
  always_comb begin
    for (int k = 1; k <= int'(STAGES); k++) begin
      {nc[k], ns[k]} = {1'b0, a_q[k-1][(k-1)*CW +: CW]}
                     + {1'b0, b_q[k-1][(k-1)*CW +: CW]}
                     + (CW+1)'(c_q[k-1]);
      sum_nx[k] = sum_q[k-1];
      sum_nx[k][(k-1)*CW +: CW] = ns[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= int'(STAGES); k++) begin
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      a_q[0]   <= in_a;
      b_q[0]   <= in_sub ? ~in_b : in_b;
      c_q[0]   <= in_carry;
      v_q[0]   <= in_valid;
      sum_q[0] <= '0;
      for (int k = 1; k < int'(STAGES); k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= int'(STAGES); k++) begin
        sum_q[k] <= sum_nx[k];
        c_q[k]   <= nc[k];
        v_q[k]   <= v_q[k-1];
      end
      // Signed overflow resolves in the rank that produces the MSB chunk.
      ovf_q <= (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
            && (sum_nx[STAGES][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    end
  end

  assign out_valid    = v_q[STAGES];
  assign out_sum      = sum_q[STAGES];
  assign out_carry    = c_q[STAGES];
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_pipe_adder_sub.sv
// Scoreboard bench for pipe_adder_sub: an 8-bit/2-stage and a 512-bit/4-stage instance
// checked against a full-width arithmetic reference model.
module tb_pipe_adder_sub;

  typedef struct {
    logic [511:0] sum;
    logic         carry;
    logic         ovf;
  } exp_t;

  logic clock;
  logic reset;

  logic       in_valid8, in_ready8, in_carry8, in_sub8;
  logic [7:0] in_a8, in_b8, out_sum8;
  logic       out_valid8, out_ready8, out_carry8, out_ovf8;

  logic         in_valid5, in_ready5, in_carry5, in_sub5;
  logic [511:0] in_a5, in_b5, out_sum5;
  logic         out_valid5, out_ready5, out_carry5, out_ovf5;

  exp_t q8[$];
  exp_t q5[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       st8 = 1'b0;
  logic [7:0] hold8;

  pipe_adder_sub #(.WIDTH(8), .STAGES(2)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .in_carry(in_carry8), .in_sub(in_sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8),
    .out_carry(out_carry8), .out_overflow(out_ovf8)
  );

  pipe_adder_sub #(.WIDTH(512), .STAGES(4)) dut512 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_a(in_a5), .in_b(in_b5),
    .in_carry(in_carry5), .in_sub(in_sub5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_sum(out_sum5),
    .out_carry(out_carry5), .out_overflow(out_ovf5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full-width modular reference; independent of chunking.
  function automatic exp_t model(input logic [511:0] a, b, input logic c, s, input int w);
    logic [512:0] mask, bb, full;
    exp_t e;
    mask   = (513'(1) << w) - 513'(1);
    bb     = s ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    full   = {1'b0, a} + bb + 513'(c);
    e.sum   = full[511:0] & mask[511:0];
    e.carry = full[w];
    e.ovf   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitors: compare every presented-and-accepted beat against the queue head.
  always @(negedge clock) begin
    if (!reset) st8 = 1'b0;
    else begin
      if (st8) begin
        check("hold_valid8", 512'(out_valid8), 512'(1));
        check("hold_sum8", 512'(out_sum8), 512'(hold8));
      end
      if (out_valid8 && !out_ready8) begin
        check("stall_in_ready8", 512'(in_ready8), 512'(0));
        st8 = 1'b1;
        hold8 = out_sum8;
      end else st8 = 1'b0;
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected8: got sum %0h with empty scoreboard", out_sum8);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("sum8", 512'(out_sum8), e.sum);
          check("carry8", 512'(out_carry8), 512'(e.carry));
          check("ovf8", 512'(out_ovf8), 512'(e.ovf));
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset && out_valid5 && out_ready5) begin
      if (q5.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected512: got sum %0h with empty scoreboard", out_sum5);
      end else begin
        exp_t e;
        e = q5.pop_front();
        check("sum512", out_sum5, e.sum);
        check("carry512", 512'(out_carry5), 512'(e.carry));
        check("ovf512", 512'(out_ovf5), 512'(e.ovf));
      end
    end
  end

  // One clock of the 8-bit driver; starts and ends 1 time unit after a rising edge.
  task automatic cycle8(input logic v, input logic [7:0] a, b, input logic c, s,
                        input logic rdy, output logic acc);
    in_valid8 = v; in_a8 = a; in_b8 = b; in_carry8 = c; in_sub8 = s; out_ready8 = rdy;
    @(negedge clock);
    acc = v && in_ready8;
    if (acc) q8.push_back(model(512'(a), 512'(b), c, s, 8));
    @(posedge clock); #1;
  endtask

  task automatic send8(input logic [7:0] a, b, input logic c, s);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      cycle8(1'b1, a, b, c, s, 1'b1, acc);
      n++;
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send8_timeout: got no acceptance expected acceptance");
    end
  endtask

  task automatic cycle5(input logic v, input logic [511:0] a, b, input logic c, s,
                        input logic rdy, output logic acc);
    in_valid5 = v; in_a5 = a; in_b5 = b; in_carry5 = c; in_sub5 = s; out_ready5 = rdy;
    @(negedge clock);
    acc = v && in_ready5;
    if (acc) q5.push_back(model(a, b, c, s, 512));
    @(posedge clock); #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle8();
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
  endtask

  // Edges from an acceptance edge until out_valid is seen (acceptance edge counts as 1).
  task automatic latency8(input string name);
    int n;
    idle8();
    n = 1;
    while (!out_valid8 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check(name, 512'(n), 512'(3));
  endtask

  task automatic drain();
    int n;
    idle8();
    in_valid5 = 1'b0; out_ready5 = 1'b1;
    n = 0;
    while ((q8.size() != 0 || q5.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain8", 512'(q8.size()), 512'(0));
    check("drain512", 512'(q5.size()), 512'(0));
  endtask

  initial begin
    logic acc;
    int   got, n;
    reset = 1'b0;
    in_valid8 = 0; in_a8 = 0; in_b8 = 0; in_carry8 = 0; in_sub8 = 0; out_ready8 = 1;
    in_valid5 = 0; in_a5 = 0; in_b5 = 0; in_carry5 = 0; in_sub5 = 0; out_ready5 = 1;
    #1;
    check("rst_out_valid8", 512'(out_valid8), 512'(0));
    check("rst_out_sum8", 512'(out_sum8), 512'(0));
    check("rst_in_ready8", 512'(in_ready8), 512'(1));
    check("rst_out_sum512", out_sum5, 512'(0));
    check("rst_out_carry512", 512'(out_carry5), 512'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Inter-nibble carry, latency, and the subtract/overflow vectors.
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    latency8("latency_first8");
    send8(8'h10, 8'h20, 1'b1, 1'b1);
    send8(8'h80, 8'h01, 1'b1, 1'b1);
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
    drain();

    // Back-to-back stream a=i, b=2i.
    for (int i = 0; i < 10; i++) send8(8'(i), 8'(2*i), 1'b0, 1'b0);
    drain();

    // Backpressure: consumer stalls for 4 cycles mid-stream.
    got = 0; n = 0;
    while (got < 10 && n < 100) begin
      cycle8(1'b1, 8'(got + 20), 8'(got * 3), 1'b0, 1'b0, !(n >= 5 && n < 9), acc);
      if (acc) got++;
      n++;
    end
    drain();

    // Reset mid-flight discards two in-flight beats.
    send8(8'h11, 8'h22, 1'b0, 1'b0);
    send8(8'h33, 8'h44, 1'b0, 1'b0);
    idle8();
    reset = 1'b0;
    #1;
    check("midrst_out_valid8", 512'(out_valid8), 512'(0));
    check("midrst_out_sum8", 512'(out_sum8), 512'(0));
    check("midrst_out_carry8", 512'(out_carry8), 512'(0));
    q8.delete();
    @(posedge clock); #1 reset = 1'b1;
    send8(8'h05, 8'h06, 1'b0, 1'b0);
    latency8("latency_after_reset8");
    drain();

    // Random 8-bit traffic with random source and sink pacing.
    got = 0; n = 0;
    while (got < 1000 && n < 20000) begin
      cycle8($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) != 0, acc);
      if (acc) got++;
      n++;
    end
    drain();

    // 512-bit: ripple across all four chunks, then random traffic.
    cycle5(1'b1, {512{1'b1}}, 512'(0), 1'b1, 1'b0, 1'b1, acc);
    check("accept512", 512'(acc), 512'(1));
    in_valid5 = 1'b0;
    n = 1;
    while (!out_valid5 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("latency512", 512'(n), 512'(5));
    got = 0; n = 0;
    while (got < 200 && n < 4000) begin
      cycle5($urandom_range(0, 3) != 0, rand512(), rand512(), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) != 0, acc);
      if (acc) got++;
      n++;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
